// File: rtl/pkg_mpu.sv
// Types and constants shared by the host interface bridge and the engine link.
package pkg_mpu;
  localparam int HIF_DEPTH   = 8;
  localparam int HIF_MAX_LEN = 1024;
  localparam int HIF_WORD_W  = 32;

  typedef struct packed {
    logic [3:0]  pkt_type;
    logic [11:0] rsvd;
    logic [15:0] len;
  } hif_hdr_t;

  typedef logic [HIF_WORD_W-1:0] mpu_if_t;

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_PAYLOAD, ST_ERR} fr_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy counter; a full FIFO accepts a push that coincides with a pop.
module sync_fifo #(
  parameter int  DEPTH = 8,
  parameter type T     = logic [31:0]
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  T     wdata,
  input  logic pop,
  output T     rdata,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign rdata   = mem[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  // NOTE: clocked state uses <= so every flop samples pre-edge values; = here would chain updates within one edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; occupancy lives in count_q, so stale entries are never presented as valid.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/host_if_bridge.sv
// Host-to-engine bridge: frames host packets into engine strobes and buffers engine replies for the host.
module host_if_bridge
  import pkg_mpu::*;
#(
  parameter int DEPTH   = HIF_DEPTH,
  parameter int WIDTH   = 32,
  parameter int MAX_LEN = HIF_MAX_LEN
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             I_Ext_Valid,
  input  logic [WIDTH-1:0] I_Ext_Data,
  output logic             O_Ext_Ready,
  output logic             O_Ext_Valid,
  output logic [WIDTH-1:0] O_Ext_Data,
  input  logic             I_Ext_Ready,
  output logic             O_Req_IF,
  output mpu_if_t          O_Data_IF,
  input  logic             I_Req_IF,
  input  mpu_if_t          I_Data_IF,
  input  logic             I_Wait,
  output logic             O_Busy,
  output logic             O_Err,
  output logic             O_Ovf
);
  localparam int RW = $clog2(MAX_LEN + 1);

  fr_state_t        state_q, state_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic             req_q, req_d;
  mpu_if_t          data_q, data_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;
  logic             in_push, in_pop, in_full, in_empty;
  logic [WIDTH-1:0] in_rdata;
  hif_hdr_t         in_hdr;
  logic             ret_pop, ret_full, ret_empty;
  mpu_if_t          ret_rdata;

  // Ready is forced low while reset is held so no host word is taken mid-reset.
  assign O_Ext_Ready = !in_full && !reset;
  assign in_push     = I_Ext_Valid && O_Ext_Ready;
  assign in_hdr      = hif_hdr_t'(32'(in_rdata));

  sync_fifo #(.DEPTH(DEPTH), .T(logic [WIDTH-1:0])) u_in_fifo (
    .clock (clock),
    .reset (reset),
    .push  (in_push),
    .wdata (I_Ext_Data),
    .pop   (in_pop),
    .rdata (in_rdata),
    .full  (in_full),
    .empty (in_empty)
  );

  assign ret_pop     = !ret_empty && I_Ext_Ready;
  assign O_Ext_Valid = !ret_empty;
  assign O_Ext_Data  = ret_empty ? '0 : WIDTH'(ret_rdata);
  assign ovf_d       = ovf_q || (I_Req_IF && ret_full && !ret_pop);

  sync_fifo #(.DEPTH(DEPTH), .T(mpu_if_t)) u_ret_fifo (
    .clock (clock),
    .reset (reset),
    .push  (I_Req_IF),
    .wdata (I_Data_IF),
    .pop   (ret_pop),
    .rdata (ret_rdata),
    .full  (ret_full),
    .empty (ret_empty)
  );

  // NOTE: every always_comb output gets a default first, so no path leaves a value unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    req_d   = 1'b0;
    data_d  = data_q;
    err_d   = err_q;
    in_pop  = 1'b0;
    unique case (state_q)
      // Entering HDR on the push itself lets the header go out the very next cycle.
      ST_IDLE: if (in_push || !in_empty) state_d = ST_HDR;
      ST_HDR: begin
        if (!in_empty && !I_Wait) begin
          in_pop = 1'b1;
          if (int'(in_hdr.len) > MAX_LEN) begin
            err_d   = 1'b1;
            state_d = ST_ERR;
          end else begin
            req_d  = 1'b1;
            data_d = mpu_if_t'(in_hdr);
            if (in_hdr.len == 16'd0) begin
              state_d = ST_IDLE;
            end else begin
              rem_d   = RW'(in_hdr.len);
              state_d = ST_PAYLOAD;
            end
          end
        end
      end
      ST_PAYLOAD: begin
        if (!in_empty && !I_Wait) begin
          in_pop = 1'b1;
          req_d  = 1'b1;
          data_d = mpu_if_t'(in_rdata);
          rem_d  = rem_q - RW'(1);
          if (rem_q == RW'(1)) state_d = ST_IDLE;
        end
      end
      ST_ERR: begin
        if (in_empty) state_d = ST_IDLE;
        else          in_pop  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      req_q   <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      req_q   <= req_d;
      data_q  <= data_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  assign O_Req_IF  = req_q;
  assign O_Data_IF = data_q;
  assign O_Busy    = (state_q != ST_IDLE);
  assign O_Err     = err_q;
  assign O_Ovf     = ovf_q;
endmodule

// File: tb/tb_host_if_bridge.sv
// Randomized bench for host_if_bridge: packet-level expectations for the framer, queue model for the return path.
module tb_host_if_bridge;
  import pkg_mpu::*;

  localparam int DEPTH   = 8;
  localparam int WIDTH   = 32;
  localparam int MAX_LEN = 1024;

  typedef logic [WIDTH-1:0] word_t;
  typedef word_t word_q_t[$];

  logic    clock = 1'b0;
  logic    reset = 1'b1;
  logic    I_Ext_Valid = 1'b0;
  word_t   I_Ext_Data = '0;
  logic    O_Ext_Ready, O_Ext_Valid;
  word_t   O_Ext_Data;
  logic    I_Ext_Ready = 1'b0;
  logic    O_Req_IF;
  mpu_if_t O_Data_IF;
  logic    I_Req_IF = 1'b0;
  mpu_if_t I_Data_IF = '0;
  logic    I_Wait = 1'b0;
  logic    O_Busy, O_Err, O_Ovf;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clock = ~clock;

  host_if_bridge #(.DEPTH(DEPTH), .WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
    .clock       (clock),
    .reset       (reset),
    .I_Ext_Valid (I_Ext_Valid),
    .I_Ext_Data  (I_Ext_Data),
    .O_Ext_Ready (O_Ext_Ready),
    .O_Ext_Valid (O_Ext_Valid),
    .O_Ext_Data  (O_Ext_Data),
    .I_Ext_Ready (I_Ext_Ready),
    .O_Req_IF    (O_Req_IF),
    .O_Data_IF   (O_Data_IF),
    .I_Req_IF    (I_Req_IF),
    .I_Data_IF   (I_Data_IF),
    .I_Wait      (I_Wait),
    .O_Busy      (O_Busy),
    .O_Err       (O_Err),
    .O_Ovf       (O_Ovf)
  );

  // Edge e is the rising edge right after falling edge e; strobes seen at falling edge k were launched by edge k-1.
  int    neg_cnt = 0;
  word_t obs_q[$];
  int    obs_edge[$];
  logic  obs_busy[$];
  int    acc_edge[$];

  always @(negedge clock) begin
    neg_cnt++;
    if (!reset && O_Req_IF) begin
      obs_q.push_back(O_Data_IF);
      obs_edge.push_back(neg_cnt - 1);
      obs_busy.push_back(O_Busy);
    end
    if (!reset && I_Ext_Valid && O_Ext_Ready) acc_edge.push_back(neg_cnt);
  end

  function automatic word_t mk_hdr(input int len);
    hif_hdr_t h;
    h.pkt_type = 4'($urandom);
    h.rsvd     = 12'($urandom);
    h.len      = 16'(len);
    return WIDTH'(h);
  endfunction

  function automatic word_q_t mk_pkt(input int len, input int n_payload);
    word_q_t p;
    p.push_back(mk_hdr(len));
    for (int i = 0; i < n_payload; i++) p.push_back(word_t'($urandom));
    return p;
  endfunction

  task automatic clear_obs();
    obs_q.delete();
    obs_edge.delete();
    obs_busy.delete();
    acc_edge.delete();
  endtask

  task automatic send_word(input word_t w, output bit ok);
    bit acc;
    int guard;
    guard = 0;
    I_Ext_Valid = 1'b1;
    I_Ext_Data  = w;
    do begin
      @(negedge clock);
      acc = O_Ext_Ready;
      @(posedge clock);
      #1;
      guard++;
    end while (!acc && guard < 200);
    ok = acc;
    I_Ext_Valid = 1'b0;
  endtask

  task automatic send_packet(input word_q_t words, output bit ok);
    bit w_ok;
    ok = 1'b1;
    foreach (words[i]) begin
      send_word(words[i], w_ok);
      if (!w_ok) ok = 1'b0;
    end
  endtask

  task automatic wait_strobes(input int n, input int budget, output bit ok);
    int guard;
    guard = 0;
    while (obs_q.size() < n && guard < budget) begin
      @(posedge clock);
      #1;
      guard++;
    end
    ok = (obs_q.size() >= n);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    idle(2);
    n_cmp++; if (O_Req_IF !== 1'b0) begin n_mis++; $display("FAIL rst_req: got %b want 0", O_Req_IF); end
    n_cmp++; if (O_Data_IF !== '0) begin n_mis++; $display("FAIL rst_data_if: got %h want 0", O_Data_IF); end
    n_cmp++; if (O_Ext_Valid !== 1'b0) begin n_mis++; $display("FAIL rst_ext_valid: got %b want 0", O_Ext_Valid); end
    n_cmp++; if (O_Ext_Data !== '0) begin n_mis++; $display("FAIL rst_ext_data: got %h want 0", O_Ext_Data); end
    n_cmp++; if (O_Ext_Ready !== 1'b0) begin n_mis++; $display("FAIL rst_ext_ready: got %b want 0", O_Ext_Ready); end
    n_cmp++; if (O_Busy !== 1'b0) begin n_mis++; $display("FAIL rst_busy: got %b want 0", O_Busy); end
    reset = 1'b0;
    #1;
    n_cmp++; if (O_Ext_Ready !== 1'b1) begin n_mis++; $display("FAIL rel_ext_ready: got %b want 1", O_Ext_Ready); end
    n_cmp++; if (O_Err !== 1'b0) begin n_mis++; $display("FAIL rel_err: got %b want 0", O_Err); end
    n_cmp++; if (O_Ovf !== 1'b0) begin n_mis++; $display("FAIL rel_ovf: got %b want 0", O_Ovf); end
    idle(1);
  endtask

  task automatic test_basic_packet();
    word_q_t pkt;
    bit ok_tx, ok_rx;
    clear_obs();
    pkt = mk_pkt(3, 3);
    send_packet(pkt, ok_tx);
    wait_strobes(4, 50, ok_rx);
    idle(4);
    n_cmp++; if (!ok_tx || !ok_rx) begin n_mis++; $display("FAIL basic_timeout: tx %b rx %b want 1 1", ok_tx, ok_rx); end
    n_cmp++; if (obs_q.size() != 4) begin n_mis++; $display("FAIL basic_count: got %0d want 4", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 4; i++) begin
      n_cmp++; if (obs_q[i] !== pkt[i]) begin n_mis++; $display("FAIL basic_data[%0d]: got %h want %h", i, obs_q[i], pkt[i]); end
      n_cmp++; if (acc_edge.size() == 0 || obs_edge[i] != acc_edge[0] + 1 + i) begin
        n_mis++; $display("FAIL basic_edge[%0d]: got %0d want %0d", i, obs_edge[i], (acc_edge.size() > 0 ? acc_edge[0] : -99) + 1 + i);
      end
      n_cmp++; if (obs_busy[i] !== (i < 3)) begin n_mis++; $display("FAIL basic_busy[%0d]: got %b want %b", i, obs_busy[i], (i < 3)); end
    end
  endtask

  task automatic test_wait_pause();
    word_q_t pkt;
    int len, c0, c1;
    bit ok_tx, ok_a, ok_b;
    clear_obs();
    len = $urandom_range(6, 10);
    pkt = mk_pkt(len, len);
    fork
      send_packet(pkt, ok_tx);
      begin
        wait_strobes(3, 100, ok_a);
        I_Wait = 1'b1;
        @(negedge clock);
        #1;
        c0 = obs_q.size();
        repeat (5) @(posedge clock);
        #1;
        I_Wait = 1'b0;
        @(negedge clock);
        #1;
        c1 = obs_q.size();
      end
    join
    wait_strobes(len + 1, 100, ok_b);
    idle(4);
    n_cmp++; if (!ok_tx || !ok_a || !ok_b) begin n_mis++; $display("FAIL pause_timeout: tx %b a %b b %b want 1 1 1", ok_tx, ok_a, ok_b); end
    n_cmp++; if (c1 != c0) begin n_mis++; $display("FAIL pause_strobes: got %0d during wait want 0", c1 - c0); end
    n_cmp++; if (obs_q.size() != len + 1) begin n_mis++; $display("FAIL pause_count: got %0d want %0d", obs_q.size(), len + 1); end
    for (int i = 0; i < obs_q.size() && i < len + 1; i++) begin
      n_cmp++; if (obs_q[i] !== pkt[i]) begin n_mis++; $display("FAIL pause_data[%0d]: got %h want %h", i, obs_q[i], pkt[i]); end
    end
  endtask

  task automatic test_len_boundaries();
    word_q_t pkt;
    bit ok_tx, ok_rx;
    clear_obs();
    pkt = mk_pkt(0, 0);
    pkt.push_back(mk_hdr(0));
    for (int i = 0; i < MAX_LEN + 1; i++) pkt.push_back(i == 0 ? mk_hdr(MAX_LEN) : word_t'($urandom));
    send_packet(pkt, ok_tx);
    wait_strobes(MAX_LEN + 3, 200, ok_rx);
    idle(4);
    n_cmp++; if (!ok_tx || !ok_rx) begin n_mis++; $display("FAIL bound_timeout: tx %b rx %b want 1 1", ok_tx, ok_rx); end
    n_cmp++; if (obs_q.size() != MAX_LEN + 3) begin n_mis++; $display("FAIL bound_count: got %0d want %0d", obs_q.size(), MAX_LEN + 3); end
    for (int i = 0; i < obs_q.size() && i < MAX_LEN + 3; i++) begin
      if (obs_q[i] !== pkt[i]) begin n_cmp++; n_mis++; $display("FAIL bound_data[%0d]: got %h want %h", i, obs_q[i], pkt[i]); end
    end
    n_cmp++; if (O_Busy !== 1'b0) begin n_mis++; $display("FAIL bound_busy: got %b want 0", O_Busy); end
    n_cmp++; if (O_Err !== 1'b0) begin n_mis++; $display("FAIL bound_err: got %b want 0", O_Err); end
  endtask

  task automatic test_bad_len();
    word_q_t bad, good;
    bit ok_tx, ok_rx;
    clear_obs();
    bad = mk_pkt(MAX_LEN + 1, 4);
    send_packet(bad, ok_tx);
    idle(10);
    n_cmp++; if (!ok_tx) begin n_mis++; $display("FAIL bad_timeout: tx %b want 1", ok_tx); end
    n_cmp++; if (obs_q.size() != 0) begin n_mis++; $display("FAIL bad_strobes: got %0d want 0", obs_q.size()); end
    n_cmp++; if (O_Err !== 1'b1) begin n_mis++; $display("FAIL bad_err: got %b want 1", O_Err); end
    n_cmp++; if (O_Busy !== 1'b0) begin n_mis++; $display("FAIL bad_busy: got %b want 0", O_Busy); end
    good = mk_pkt(1, 1);
    send_packet(good, ok_tx);
    wait_strobes(2, 50, ok_rx);
    idle(4);
    n_cmp++; if (obs_q.size() != 2) begin n_mis++; $display("FAIL bad_recover_count: got %0d want 2", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 2; i++) begin
      n_cmp++; if (obs_q[i] !== good[i]) begin n_mis++; $display("FAIL bad_recover_data[%0d]: got %h want %h", i, obs_q[i], good[i]); end
    end
  endtask

  task automatic test_in_backpressure();
    word_q_t pkt;
    int idx;
    bit acc, ok_w, ok_rx;
    clear_obs();
    pkt = mk_pkt(11, 11);
    I_Wait = 1'b1;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      I_Ext_Valid = 1'b1;
      I_Ext_Data  = pkt[idx];
      @(negedge clock);
      acc = O_Ext_Ready;
      @(posedge clock);
      #1;
      if (acc) idx++;
    end
    I_Ext_Valid = 1'b0;
    n_cmp++; if (idx != DEPTH) begin n_mis++; $display("FAIL bp_accepted: got %0d want %0d", idx, DEPTH); end
    n_cmp++; if (O_Ext_Ready !== 1'b0) begin n_mis++; $display("FAIL bp_ready: got %b want 0", O_Ext_Ready); end
    n_cmp++; if (obs_q.size() != 0) begin n_mis++; $display("FAIL bp_strobes_while_wait: got %0d want 0", obs_q.size()); end
    I_Wait = 1'b0;
    while (idx < 12) begin
      send_word(pkt[idx], ok_w);
      idx++;
    end
    wait_strobes(12, 60, ok_rx);
    idle(4);
    n_cmp++; if (obs_q.size() != 12) begin n_mis++; $display("FAIL bp_count: got %0d want 12", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 12; i++) begin
      n_cmp++; if (obs_q[i] !== pkt[i]) begin n_mis++; $display("FAIL bp_data[%0d]: got %h want %h", i, obs_q[i], pkt[i]); end
    end
  endtask

  task automatic test_return_overflow();
    mpu_if_t sent[$];
    I_Ext_Ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      I_Req_IF  = 1'b1;
      I_Data_IF = mpu_if_t'($urandom);
      sent.push_back(I_Data_IF);
      @(posedge clock);
      #1;
      if (i == DEPTH - 1) begin
        n_cmp++; if (O_Ovf !== 1'b0) begin n_mis++; $display("FAIL ovf_early: got %b want 0", O_Ovf); end
      end
    end
    I_Req_IF = 1'b0;
    n_cmp++; if (O_Ovf !== 1'b1) begin n_mis++; $display("FAIL ovf_flag: got %b want 1", O_Ovf); end
    I_Ext_Ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clock);
      n_cmp++; if (O_Ext_Valid !== 1'b1 || O_Ext_Data !== sent[i]) begin
        n_mis++; $display("FAIL ovf_ret[%0d]: got %b/%h want 1/%h", i, O_Ext_Valid, O_Ext_Data, sent[i]);
      end
      @(posedge clock);
      #1;
    end
    @(negedge clock);
    n_cmp++; if (O_Ext_Valid !== 1'b0) begin n_mis++; $display("FAIL ovf_drained: got %b want 0", O_Ext_Valid); end
    @(posedge clock);
    #1;
    I_Ext_Ready = 1'b0;
  endtask

  task automatic test_return_random();
    mpu_if_t mq[$];
    for (int c = 0; c < 90; c++) begin
      bit req, rdy;
      mpu_if_t d;
      if (c < 10) begin
        req = 1'b1; rdy = 1'b0;
      end else if (c < 75) begin
        req = ($urandom_range(0, 3) != 0); rdy = ($urandom_range(0, 1) != 0);
      end else begin
        req = 1'b0; rdy = 1'b1;
      end
      d = mpu_if_t'($urandom);
      I_Req_IF = req; I_Data_IF = d; I_Ext_Ready = rdy;
      @(negedge clock);
      n_cmp++; if (O_Ext_Valid !== (mq.size() != 0)) begin
        n_mis++; $display("FAIL rnd_valid[%0d]: got %b want %b", c, O_Ext_Valid, (mq.size() != 0));
      end
      if (mq.size() != 0) begin
        n_cmp++; if (O_Ext_Data !== mq[0]) begin n_mis++; $display("FAIL rnd_data[%0d]: got %h want %h", c, O_Ext_Data, mq[0]); end
      end
      if (rdy && mq.size() != 0) void'(mq.pop_front());
      if (req && mq.size() < DEPTH) mq.push_back(d);
      @(posedge clock);
      #1;
    end
    I_Req_IF = 1'b0;
    I_Ext_Ready = 1'b0;
  endtask

  task automatic test_reset_mid_packet();
    word_q_t pkt, nxt;
    bit ok_tx, ok_rx;
    I_Ext_Ready = 1'b0;
    repeat (2) begin
      I_Req_IF = 1'b1; I_Data_IF = mpu_if_t'($urandom);
      idle(1);
    end
    I_Req_IF = 1'b0;
    I_Wait = 1'b1;
    pkt = mk_pkt(4, 4);
    send_packet(pkt, ok_tx);
    clear_obs();
    I_Wait = 1'b0;
    wait_strobes(2, 30, ok_rx);
    n_cmp++; if (!ok_tx || !ok_rx) begin n_mis++; $display("FAIL mid_setup: tx %b rx %b want 1 1", ok_tx, ok_rx); end
    reset = 1'b1;
    #1;
    n_cmp++; if (O_Req_IF !== 1'b0) begin n_mis++; $display("FAIL mid_req: got %b want 0", O_Req_IF); end
    n_cmp++; if (O_Data_IF !== '0) begin n_mis++; $display("FAIL mid_data_if: got %h want 0", O_Data_IF); end
    n_cmp++; if (O_Ext_Valid !== 1'b0) begin n_mis++; $display("FAIL mid_ext_valid: got %b want 0", O_Ext_Valid); end
    n_cmp++; if (O_Ext_Data !== '0) begin n_mis++; $display("FAIL mid_ext_data: got %h want 0", O_Ext_Data); end
    n_cmp++; if (O_Ext_Ready !== 1'b0) begin n_mis++; $display("FAIL mid_ext_ready: got %b want 0", O_Ext_Ready); end
    n_cmp++; if (O_Busy !== 1'b0) begin n_mis++; $display("FAIL mid_busy: got %b want 0", O_Busy); end
    n_cmp++; if (O_Err !== 1'b0) begin n_mis++; $display("FAIL mid_err: got %b want 0", O_Err); end
    n_cmp++; if (O_Ovf !== 1'b0) begin n_mis++; $display("FAIL mid_ovf: got %b want 0", O_Ovf); end
    idle(2);
    reset = 1'b0;
    #1;
    n_cmp++; if (O_Ext_Ready !== 1'b1) begin n_mis++; $display("FAIL mid_ready_after: got %b want 1", O_Ext_Ready); end
    clear_obs();
    nxt = mk_pkt(2, 2);
    send_packet(nxt, ok_tx);
    wait_strobes(3, 40, ok_rx);
    idle(4);
    n_cmp++; if (obs_q.size() != 3) begin n_mis++; $display("FAIL mid_next_count: got %0d want 3", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 3; i++) begin
      n_cmp++; if (obs_q[i] !== nxt[i]) begin n_mis++; $display("FAIL mid_next_data[%0d]: got %h want %h", i, obs_q[i], nxt[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_packet();
    test_wait_pause();
    test_len_boundaries();
    test_bad_len();
    test_in_backpressure();
    test_return_overflow();
    test_return_random();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/host_if_bridge.md
HOST_IF_BRIDGE -- requirements
Module: host_if_bridge

Interface
REQ-001 SHALL have parameter DEPTH, default 8, giving the entries per FIFO (power of two, at least 2).
REQ-002 SHALL have parameter WIDTH, default 32, giving the external word width.
REQ-003 SHALL have parameter MAX_LEN, default 1024, giving the maximum payload words per packet.
REQ-004 SHALL have port clock, input, 1 bit: the single clock.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port I_Ext_Valid, input, 1 bit: host word valid.
REQ-007 SHALL have port I_Ext_Data, input, WIDTH bits: host word.
REQ-008 SHALL have port O_Ext_Ready, output, 1 bit: bridge can accept a host word.
REQ-009 SHALL have port O_Ext_Valid, output, 1 bit: return word valid.
REQ-010 SHALL have port O_Ext_Data, output, WIDTH bits: return word.
REQ-011 SHALL have port I_Ext_Ready, input, 1 bit: host accepts the return word.
REQ-012 SHALL have port O_Req_IF, output, 1 bit: one-cycle word strobe to engine I_Req_IF.
REQ-013 SHALL have port O_Data_IF, output, mpu_if_t: word to engine I_Data_IF.
REQ-014 SHALL have port I_Req_IF, input, 1 bit: engine O_Req_IF strobe.
REQ-015 SHALL have port I_Data_IF, input, mpu_if_t: engine O_Data_IF word.
REQ-016 SHALL have port I_Wait, input, 1 bit: engine O_Wait; while high, no word is forwarded.
REQ-017 SHALL have port O_Busy, output, 1 bit: framer is not in IDLE.
REQ-018 SHALL have port O_Err, output, 1 bit: sticky flag, bad header length.
REQ-019 SHALL have port O_Ovf, output, 1 bit: sticky flag, return FIFO overflow.

Function
REQ-020 SHALL drive O_Ext_Ready = !in_fifo_full; a word is written when I_Ext_Valid && O_Ext_Ready.
REQ-021 SHALL run the framer FSM through IDLE, HDR, PAYLOAD, ERR: IDLE goes to HDR when the in-FIFO is non-empty.
REQ-022 SHALL, in HDR with I_Wait low, pop the header and forward it; with LEN=hdr[15:0] and 0<LEN<=MAX_LEN, load remaining=LEN and go to PAYLOAD.
REQ-023 SHALL treat LEN==0 as a header-only packet: forward the header and return to IDLE.
REQ-024 SHALL, when LEN>MAX_LEN, not forward the header, set O_Err and go to ERR.
REQ-025 SHALL, in ERR, pop and discard words until the in-FIFO is empty, then return to IDLE.
REQ-026 SHALL, in PAYLOAD, forward one word per cycle whenever the FIFO is non-empty and I_Wait is low, decrementing remaining; after the word with remaining==1 it SHALL go to IDLE.
REQ-027 SHALL register O_Req_IF and O_Data_IF: a word accepted at cycle t into an empty FIFO appears at t+1 if I_Wait is low; sustained throughput is 1 word/cycle.
REQ-028 SHALL hold the head word and suppress O_Req_IF while I_Wait is high; there SHALL be no loss or duplication.
REQ-029 SHALL write I_Data_IF into the return FIFO on each I_Req_IF; if the FIFO is full, the word SHALL be dropped and O_Ovf set.
REQ-030 SHALL present O_Ext_Valid = !ret_fifo_empty with the head word on O_Ext_Data, popping on O_Ext_Valid && I_Ext_Ready.
REQ-031 SHALL, on simultaneous push and pop of a full FIFO, perform both and leave the count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-032 SHALL drive O_Busy = (state != IDLE).

Reset
REQ-033 SHALL, on reset, set state=IDLE, empty both FIFOs, set remaining=0, and clear O_Err and O_Ovf.
REQ-034 SHALL, while reset is asserted, drive O_Req_IF=0, O_Data_IF='0, O_Ext_Valid=0, O_Ext_Data='0, O_Ext_Ready=0, and O_Busy=0.
REQ-035 SHALL, on reset mid-packet, discard the partial packet; O_Ext_Ready SHALL return to 1 in the first cycle after deassertion.

Structure
REQ-036 SHALL place the host header typedef (type[31:28], len[15:0]) and the constants HIF_DEPTH and HIF_MAX_LEN in pkg_mpu.
REQ-037 SHALL use one sub-module, sync_fifo (parameterised DEPTH and type), instantiated for the in-path and the return path.

Verification
REQ-038 SHALL cover: header LEN=3 plus 3 words, I_Wait=0 -> 4 O_Req_IF strobes on consecutive cycles starting one cycle after the header is accepted; O_Busy falls after the 4th.
REQ-039 SHALL cover: I_Wait held high 5 cycles mid-payload -> strobes pause, order is preserved, and the total is still LEN+1.
REQ-040 SHALL cover: header LEN=1025 -> no strobe, O_Err=1, following words are discarded, and the FSM returns to IDLE.
REQ-041 SHALL cover: I_Ext_Valid held high for 12 words with I_Wait=1 -> O_Ext_Ready=0 after 8 accepted words, and no data is lost after I_Wait falls.
REQ-042 SHALL cover: 9 I_Req_IF pulses with I_Ext_Ready=0 -> 8 words are retained, O_Ovf=1, and words return in order.
REQ-043 SHALL cover: reset asserted in the 2nd payload cycle -> all outputs are at their reset values, and the next packet is forwarded correctly.
